shift_tx: RTL and testbench

SHIFT_TX -- requirements
Module: shift_tx

---
 rtl/shift_tx_pkg.sv | 16 +
 rtl/shift_tx.sv | 154 +++++++++++++++
 tb/tb_shift_tx.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_tx_pkg.sv
// Shared types for shift_tx: FSM state encodings and the state enum.
package shift_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOW   = 2'd1;
  localparam logic [1:0] ST_HIGH  = 2'd2;
  localparam logic [1:0] ST_LATCH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    LOW   = ST_LOW,
    HIGH  = ST_HIGH,
    LATCH = ST_LATCH
  } shift_tx_state_t;

endpackage

// File: rtl/shift_tx.sv
// shift_tx: tick-paced serialiser for an external shift register (sclk/sdo/latch), 2*WIDTH+1 ticks per word.
// Accepts only in IDLE via o_ready, no queuing; define SHIFT_TX_READBACK_EN to add i_sdi capture on o_rdata/o_rvalid.
module shift_tx
  import shift_tx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_sclk,
  output logic             o_sdo,
  output logic             o_latch,
  output logic             o_busy,
  output logic             o_done
`ifdef SHIFT_TX_READBACK_EN
  ,
  input  logic             i_sdi,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid
`endif
);

  localparam int CW = $clog2(WIDTH);

  shift_tx_state_t  r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_ready, r_busy, r_sclk, r_sdo, r_latch, r_done;
  logic             w_sclk_nxt, w_sdo_nxt, w_latch_nxt, w_done_nxt, w_ready_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_sclk_nxt  = r_sclk;
    w_sdo_nxt   = r_sdo;
    w_latch_nxt = r_latch;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        // Ticks here are ignored, including one coincident with acceptance.
        if (i_valid) begin
          w_state_nxt = LOW;
          w_shift_nxt = i_data;
          w_cnt_nxt   = CW'(WIDTH - 1);
          w_sdo_nxt   = (MSB_FIRST != 0) ? i_data[WIDTH-1] : i_data[0];
          w_sclk_nxt  = 1'b0;
          w_latch_nxt = 1'b0;
        end
      end
      LOW: begin
        if (i_tick) begin
          w_state_nxt = HIGH;
          w_sclk_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (i_tick) begin
          w_sclk_nxt = 1'b0;
          if (r_cnt == '0) begin
            w_state_nxt = LATCH;
            w_latch_nxt = 1'b1;
          end else begin
            w_state_nxt = LOW;
            w_cnt_nxt   = r_cnt - CW'(1);
            if (MSB_FIRST != 0) begin
              w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
              w_sdo_nxt   = r_shift[WIDTH-2];
            end else begin
              w_shift_nxt = {1'b0, r_shift[WIDTH-1:1]};
              w_sdo_nxt   = r_shift[1];
            end
          end
        end
      end
      LATCH: begin
        if (i_tick) begin
          w_state_nxt = IDLE;
          w_latch_nxt = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sclk_nxt  = 1'b0;
        w_latch_nxt = 1'b0;
      end
    endcase
    w_ready_nxt = (w_state_nxt == IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdo   <= 1'b0;
      r_latch <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= ~w_ready_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sdo   <= w_sdo_nxt;
      r_latch <= w_latch_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_ready = r_ready;
  assign o_busy  = r_busy;
  assign o_sclk  = r_sclk;
  assign o_sdo   = r_sdo;
  assign o_latch = r_latch;
  assign o_done  = r_done;

`ifdef SHIFT_TX_READBACK_EN
  logic [WIDTH-1:0] r_cap, r_rdata;
  logic             r_rvalid;

  // i_sdi is sampled on the LOW->HIGH tick, filling r_cap in transmit order.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cap    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      if (i_tick && (r_state == LOW)) begin
        r_cap <= (MSB_FIRST != 0) ? {r_cap[WIDTH-2:0], i_sdi} : {i_sdi, r_cap[WIDTH-1:1]};
      end
      if (i_tick && (r_state == LATCH)) begin
        r_rdata  <= r_cap;
        r_rvalid <= 1'b1;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
`endif

endmodule

// File: tb/tb_shift_tx.sv
// Directed bench for shift_tx: MSB-first and LSB-first instances sharing clock, reset and a 1-in-6 tick.
module tb_shift_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        a_ready, a_sclk, a_sdo, a_latch, a_busy, a_done;
  logic        b_ready, b_sclk, b_sdo, b_latch, b_busy, b_done;
`ifdef SHIFT_TX_READBACK_EN
  logic [15:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid;
`endif

  int checks = 0;
  int errors = 0;
  int ph = 0;
  int cycles = 0;

  // Per-instance monitor state: index 0 = MSB-first DUT, 1 = LSB-first DUT.
  logic [31:0] m_bits[2];
  int          m_nbits[2], m_ticks[2], m_done[2], m_latch[2], m_rise[2];
  logic        m_first[2], prev_sclk[2], prev_latch[2], busy_prev[2];
  logic [15:0] m_word[2];
  int          m_wbits[2], m_wticks[2], m_wlatch[2], m_wrise[2];

  always #5 clk = ~clk;

  shift_tx #(.WIDTH(16), .MSB_FIRST(1)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick), .i_data(data_a), .i_valid(valid_a),
    .o_ready(a_ready), .o_sclk(a_sclk), .o_sdo(a_sdo), .o_latch(a_latch), .o_busy(a_busy), .o_done(a_done)
`ifdef SHIFT_TX_READBACK_EN
    , .i_sdi(a_sdo), .o_rdata(a_rdata), .o_rvalid(a_rvalid)
`endif
  );

  shift_tx #(.WIDTH(16), .MSB_FIRST(0)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_tick(tick), .i_data(data_b), .i_valid(valid_b),
    .o_ready(b_ready), .o_sclk(b_sclk), .o_sdo(b_sdo), .o_latch(b_latch), .o_busy(b_busy), .o_done(b_done)
`ifdef SHIFT_TX_READBACK_EN
    , .i_sdi(b_sdo), .o_rdata(b_rdata), .o_rvalid(b_rvalid)
`endif
  );

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      m_bits[k] = '0; m_nbits[k] = 0; m_ticks[k] = 0; m_done[k] = 0; m_latch[k] = 0; m_rise[k] = 0;
      m_first[k] = 1'b0; prev_sclk[k] = 1'b0; prev_latch[k] = 1'b0; busy_prev[k] = 1'b0;
      m_word[k] = '0; m_wbits[k] = 0; m_wticks[k] = 0; m_wlatch[k] = 0; m_wrise[k] = 0;
    end
  endtask

  task automatic mon(input int k, input logic sclk, input logic sdo, input logic latch,
                     input logic done, input logic busy);
    if (busy_prev[k] && tick) m_ticks[k]++;
    if (sclk && !prev_sclk[k]) begin
      if (m_nbits[k] == 0) m_first[k] = sdo;
      m_bits[k] = {m_bits[k][30:0], sdo};
      m_nbits[k]++;
    end
    if (latch) m_latch[k]++;
    if (latch && !prev_latch[k]) m_rise[k]++;
    if (done) begin
      m_done[k]++;
      m_word[k] = m_bits[k][15:0]; m_wbits[k] = m_nbits[k]; m_wticks[k] = m_ticks[k];
      m_wlatch[k] = m_latch[k]; m_wrise[k] = m_rise[k];
      m_bits[k] = '0; m_nbits[k] = 0; m_ticks[k] = 0; m_latch[k] = 0; m_rise[k] = 0;
    end
    prev_sclk[k] = sclk; prev_latch[k] = latch; busy_prev[k] = busy;
  endtask

  // One clock: sample outputs 1 time unit after the edge, then drive the next tick.
  task automatic cyc();
    @(posedge clk);
    #1;
    cycles++;
    if (cycles > 60000) begin
      $display("FAIL cycle_budget got %0d cycles limit 60000", cycles);
      $fatal(1, "cycle budget exhausted");
    end
    mon(0, a_sclk, a_sdo, a_latch, a_done, a_busy);
    mon(1, b_sclk, b_sdo, b_latch, b_done, b_busy);
    ph = (ph + 1) % 6;
    tick = (ph == 0);
  endtask

  task automatic wait_done(input int k, output bit timed_out);
    int start = m_done[k];
    int n = 0;
    while (m_done[k] == start && n < 2000) begin cyc(); n++; end
    timed_out = (m_done[k] == start);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    valid_a = 1'b1; data_a = 16'hFFFF;
    for (int i = 0; i < 8; i++) cyc();
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", a_ready); end
    checks++; if (a_busy  !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", a_busy); end
    checks++; if (a_sclk  !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", a_sclk); end
    checks++; if (a_sdo   !== 1'b0) begin errors++; $display("FAIL rst_sdo got %b exp 0", a_sdo); end
    checks++; if (a_latch !== 1'b0) begin errors++; $display("FAIL rst_latch got %b exp 0", a_latch); end
    checks++; if (a_done  !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", a_done); end
`ifdef SHIFT_TX_READBACK_EN
    checks++; if (a_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got %h exp 0000", a_rdata); end
`endif
    valid_a = 1'b0;
    rst_n = 1'b1;
    cyc(); cyc();
    clr();
  endtask

  task automatic test_basic();
    bit to;
    valid_a = 1'b1; data_a = 16'hA5C3;
    cyc();
    valid_a = 1'b0;
    checks++; if (a_busy !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL basic_accept got busy=%b ready=%b exp busy=1 ready=0", a_busy, a_ready); end
    checks++; if (a_sdo !== 1'b1) begin errors++; $display("FAIL basic_first_sdo got %b exp 1", a_sdo); end
    wait_done(0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no o_done exp o_done"); end
    checks++; if (m_word[0] !== 16'hA5C3) begin errors++; $display("FAIL basic_word got %h exp a5c3", m_word[0]); end
    checks++; if (m_wbits[0] != 16) begin errors++; $display("FAIL basic_nbits got %0d exp 16", m_wbits[0]); end
    checks++; if (m_wticks[0] != 33) begin errors++; $display("FAIL basic_ticks got %0d exp 33", m_wticks[0]); end
    checks++; if (m_wrise[0] != 1 || m_wlatch[0] != 6) begin errors++; $display("FAIL basic_latch got rises=%0d cycles=%0d exp 1 and 6", m_wrise[0], m_wlatch[0]); end
    checks++; if (a_ready !== 1'b1 || a_latch !== 1'b0) begin errors++; $display("FAIL basic_end got ready=%b latch=%b exp 1 0", a_ready, a_latch); end
    cyc();
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", a_done); end
  endtask

  task automatic test_lsb_first();
    bit to;
    valid_b = 1'b1; data_b = 16'h0001;
    cyc();
    valid_b = 1'b0;
    wait_done(1, to);
    checks++; if (to) begin errors++; $display("FAIL lsb_timeout got no o_done exp o_done"); end
    checks++; if (m_first[1] !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got %b exp 1", m_first[1]); end
    checks++; if (m_word[1] !== 16'h8000 || m_wbits[1] != 16) begin errors++; $display("FAIL lsb_order got %h/%0d exp 8000/16", m_word[1], m_wbits[1]); end
`ifdef SHIFT_TX_READBACK_EN
    checks++; if (b_rdata !== 16'h0001) begin errors++; $display("FAIL lsb_rdata got %h exp 0001", b_rdata); end
`endif
  endtask

  task automatic test_back_to_back();
    bit to;
    int n;
    valid_a = 1'b1; data_a = 16'h1234;
    cyc();
    data_a = 16'h5678;
    wait_done(0, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout1 got no o_done exp o_done"); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", a_ready); end
    checks++; if (m_word[0] !== 16'h1234) begin errors++; $display("FAIL b2b_word1 got %h exp 1234", m_word[0]); end
    n = 0;
    do begin cyc(); n++; end while (!a_busy && n < 5);
    valid_a = 1'b0;
    checks++; if (n > 2 || a_busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got %0d cycles exp <=2", n); end
    wait_done(0, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout2 got no o_done exp o_done"); end
    checks++; if (m_word[0] !== 16'h5678 || m_wticks[0] != 33) begin errors++; $display("FAIL b2b_word2 got %h/%0d exp 5678/33", m_word[0], m_wticks[0]); end
  endtask

  task automatic test_tick_coincident();
    bit to;
    int n;
    cyc();
    valid_a = 1'b1; data_a = 16'h00FF;
    ph = 0; tick = 1'b1;
    cyc();
    valid_a = 1'b0;
    checks++; if (a_busy !== 1'b1 || a_sclk !== 1'b0) begin errors++; $display("FAIL tick_accept got busy=%b sclk=%b exp 1 0", a_busy, a_sclk); end
    n = 0;
    while (a_sclk !== 1'b1 && n < 50) begin cyc(); n++; end
    checks++; if (n != 6) begin errors++; $display("FAIL tick_first_sclk got %0d cycles exp 6", n); end
    wait_done(0, to);
    checks++; if (to || m_word[0] !== 16'h00FF) begin errors++; $display("FAIL tick_word got %h exp 00ff", m_word[0]); end
  endtask

  task automatic test_reset_mid();
    int d0, n;
    d0 = m_done[0];
    valid_a = 1'b1; data_a = 16'hA5C3;
    cyc();
    valid_a = 1'b0;
    n = 0;
    while (m_nbits[0] < 5 && n < 500) begin cyc(); n++; end
    checks++; if (m_nbits[0] != 5 || a_sclk !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d edges sclk=%b exp 5 1", m_nbits[0], a_sclk); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_sclk !== 1'b0 || a_latch !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL mid_abort got sclk=%b latch=%b busy=%b exp 0 0 0", a_sclk, a_latch, a_busy); end
    cyc(); cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 120; i++) cyc();
    checks++; if (m_done[0] != d0) begin errors++; $display("FAIL mid_no_done got %0d exp %0d", m_done[0], d0); end
    checks++; if (a_ready !== 1'b1 || a_latch !== 1'b0) begin errors++; $display("FAIL mid_release got ready=%b latch=%b exp 1 0", a_ready, a_latch); end
    clr();
  endtask

`ifdef SHIFT_TX_READBACK_EN
  task automatic test_readback();
    bit to;
    valid_a = 1'b1; data_a = 16'hBEEF;
    cyc();
    valid_a = 1'b0;
    wait_done(0, to);
    checks++; if (to || a_rvalid !== 1'b1) begin errors++; $display("FAIL rb_rvalid got %b exp 1 with o_done", a_rvalid); end
    checks++; if (a_rdata !== 16'hBEEF) begin errors++; $display("FAIL rb_rdata got %h exp beef", a_rdata); end
    cyc();
    checks++; if (a_rvalid !== 1'b0) begin errors++; $display("FAIL rb_rvalid_width got %b exp 0", a_rvalid); end
  endtask
`endif

  initial begin
    clr();
    test_reset();
    test_basic();
    test_lsb_first();
    test_back_to_back();
    test_tick_coincident();
    test_reset_mid();
`ifdef SHIFT_TX_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
